daqo_arbiter: RTL and testbench

Round-robin arbiter that merges NSRC producer record queues (each a length FIFO plus a data FIFO) into the single daqo length/data queue pair that the Ethernet MAC drains. Records move atomically: every data word of a record is copied before its length is committed downstream, so the MAC never sees a length whose data is not yet present. Zero-length and oversize records are removed here, so every record the MAC packs fits its frame limit.

---
 rtl/daqo_arb_pkg.sv | 16 +
 rtl/daqo_arbiter_rr_pick.sv | 32 +++
 rtl/daqo_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_daqo_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daqo_arb_pkg.sv
// daqo_arb_pkg: shared definitions for the daqo record arbiter.
//   - 3-bit state encoding for the arbiter FSM
//   - default largest legal record length in 32-bit words (MAC frame limit)
package daqo_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StLen     = 3'd1;
    localparam state_t StCopy    = 3'd2;
    localparam state_t StDiscard = 3'd3;
    localparam state_t StCommit  = 3'd4;

    localparam int unsigned DefaultMaxLen = 375;

endpackage

// File: rtl/daqo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req_i   in   NumReq  request vector
//   last_i  in   GrantW  index granted last time
//   grant_o out  GrantW  first set request searching upward from last_i+1 (mod NumReq)
//   any_o   out  1       at least one request is set
module rr_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned GrantW = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [GrantW-1:0] last_i,
    output logic [GrantW-1:0] grant_o,
    output logic              any_o
);

    logic [GrantW-1:0] idx;

    // k runs 1..NumReq so the previous winner is considered last.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            idx = GrantW'((32'(last_i) + k) % NumReq);
            if (!any_o && req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/daqo_arbiter.sv
// daqo_arbiter: round-robin merge of NSRC producer record queues (length FIFO + data FIFO)
// into the single daqo length/data queue pair drained by the Ethernet MAC.
// A record's data words are all copied before its length is written, so the MAC never
// sees a length without its data. Zero-length and oversize records are dropped here.
//   clk, rst             clock, synchronous active-high reset
//   src_enable           per-source arbitration enable
//   src_len_ready        per-source length FIFO non-empty
//   src_len              FWFT length heads, source i at [i*LEN_BITS +: LEN_BITS]
//   src_len_rd_en        per-source length pop
//   src_data             FWFT data heads, source i at [i*32 +: 32]
//   src_data_rd_en       per-source data pop
//   daqo_data/_wr_en     MAC data queue write; daqo_data_full blocks it
//   daqo_len/_wr_en      MAC length queue write; daqo_len_full blocks it
//   drop_cnt             wrapping count of dropped records
//   grant_dbg            {state, grant}
module daqo_arbiter
    import daqo_arb_pkg::*;
#(
    parameter int unsigned NSRC     = 4,
    parameter int unsigned LEN_BITS = 9,
    parameter int unsigned MAX_LEN  = DefaultMaxLen
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSRC-1:0]            src_enable,
    input  logic [NSRC-1:0]            src_len_ready,
    input  logic [NSRC*LEN_BITS-1:0]   src_len,
    output logic [NSRC-1:0]            src_len_rd_en,
    input  logic [NSRC*32-1:0]         src_data,
    output logic [NSRC-1:0]            src_data_rd_en,
    output logic [31:0]                daqo_data,
    output logic                       daqo_data_wr_en,
    input  logic                       daqo_data_full,
    output logic [LEN_BITS-1:0]        daqo_len,
    output logic                       daqo_len_wr_en,
    input  logic                       daqo_len_full,
    output logic [15:0]                drop_cnt,
    output logic [$clog2(NSRC)+2:0]    grant_dbg
);

    localparam int unsigned GW = $clog2(NSRC);
    localparam logic [LEN_BITS-1:0] MaxLenW = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] OneW    = LEN_BITS'(1);

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q, last_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [LEN_BITS-1:0]   remain_q, remain_d;
    logic [15:0]           drop_q, drop_d;

    logic [LEN_BITS-1:0]   len_arr [NSRC];
    logic [31:0]           data_arr [NSRC];
    logic [LEN_BITS-1:0]   head_len;

    logic [NSRC-1:0]       req;
    logic [GW-1:0]         pick_grant;
    logic                  pick_any;

    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign len_arr[i]  = src_len[i*LEN_BITS +: LEN_BITS];
        assign data_arr[i] = src_data[i*32 +: 32];
    end

    assign head_len = len_arr[grant_q];
    assign req      = src_len_ready & src_enable;

    rr_pick #(
        .NumReq (NSRC),
        .GrantW (GW)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        len_d    = len_q;
        remain_d = remain_q;
        drop_d   = drop_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = StLen;
                end
            end
            StLen: begin
                len_d    = head_len;
                remain_d = head_len;
                if (head_len == '0) begin
                    drop_d  = drop_q + 16'd1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end else if (head_len > MaxLenW) begin
                    // Oversize data words still have to be drained from the source.
                    drop_d  = drop_q + 16'd1;
                    state_d = StDiscard;
                end else begin
                    state_d = StCopy;
                end
            end
            StCopy: begin
                if (!daqo_data_full) begin
                    remain_d = remain_q - OneW;
                    if (remain_q == OneW) begin
                        state_d = StCommit;
                    end
                end
            end
            StDiscard: begin
                remain_d = remain_q - OneW;
                if (remain_q == OneW) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            StCommit: begin
                if (!daqo_len_full) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes are gated by rst so they drop in the very cycle reset is applied.
    always_comb begin
        src_len_rd_en   = '0;
        src_data_rd_en  = '0;
        daqo_data       = '0;
        daqo_data_wr_en = 1'b0;
        daqo_len        = '0;
        daqo_len_wr_en  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StLen: begin
                    src_len_rd_en[grant_q] = 1'b1;
                end
                StCopy: begin
                    daqo_data = data_arr[grant_q];
                    if (!daqo_data_full) begin
                        src_data_rd_en[grant_q] = 1'b1;
                        daqo_data_wr_en         = 1'b1;
                    end
                end
                StDiscard: begin
                    src_data_rd_en[grant_q] = 1'b1;
                end
                StCommit: begin
                    daqo_len = len_q;
                    if (!daqo_len_full) begin
                        daqo_len_wr_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= GW'(NSRC - 1);
            len_q    <= '0;
            remain_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            drop_q   <= drop_d;
        end
    end

    assign drop_cnt  = drop_q;
    assign grant_dbg = {state_q, grant_q};

endmodule

// File: tb/tb_daqo_arbiter.sv
// Self-checking bench for daqo_arbiter: producer FIFO models feed the DUT, a monitor logs
// every MAC-side write with its cycle stamp, and directed scenario tasks check the logs.
module tb_daqo_arbiter;

    localparam int unsigned NSRC = 4;
    localparam int unsigned LB   = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NSRC-1:0]    src_enable = '0;
    logic [NSRC-1:0]    src_len_ready;
    logic [NSRC*LB-1:0] src_len;
    logic [NSRC-1:0]    src_len_rd_en;
    logic [NSRC*32-1:0] src_data;
    logic [NSRC-1:0]    src_data_rd_en;
    logic [31:0]        daqo_data;
    logic               daqo_data_wr_en;
    logic               daqo_data_full = 1'b0;
    logic [LB-1:0]      daqo_len;
    logic               daqo_len_wr_en;
    logic               daqo_len_full = 1'b0;
    logic [15:0]        drop_cnt;
    logic [4:0]         grant_dbg;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    daqo_arbiter #(
        .NSRC     (NSRC),
        .LEN_BITS (LB),
        .MAX_LEN  (375)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .src_enable      (src_enable),
        .src_len_ready   (src_len_ready),
        .src_len         (src_len),
        .src_len_rd_en   (src_len_rd_en),
        .src_data        (src_data),
        .src_data_rd_en  (src_data_rd_en),
        .daqo_data       (daqo_data),
        .daqo_data_wr_en (daqo_data_wr_en),
        .daqo_data_full  (daqo_data_full),
        .daqo_len        (daqo_len),
        .daqo_len_wr_en  (daqo_len_wr_en),
        .daqo_len_full   (daqo_len_full),
        .drop_cnt        (drop_cnt),
        .grant_dbg       (grant_dbg)
    );

    // Producer FIFO models (FWFT); flushed on reset together with the DUT.
    logic [LB-1:0] lmem [NSRC][2048];
    logic [31:0]   dmem [NSRC][2048];
    logic [10:0]   lhead [NSRC] = '{default: '0};
    logic [10:0]   dhead [NSRC] = '{default: '0};
    logic [10:0]   ltail [NSRC] = '{default: '0};
    logic [10:0]   dtail [NSRC] = '{default: '0};
    int            lpops [NSRC] = '{default: 0};
    int            dpops [NSRC] = '{default: 0};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign src_len_ready[i]     = (lhead[i] != ltail[i]);
        assign src_len[i*LB +: LB]  = lmem[i][lhead[i]];
        assign src_data[i*32 +: 32] = dmem[i][dhead[i]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (rst) begin
                lhead[i] <= ltail[i];
                dhead[i] <= dtail[i];
            end else begin
                if (src_len_rd_en[i]) begin
                    lhead[i] <= lhead[i] + 11'd1;
                    lpops[i] <= lpops[i] + 1;
                end
                if (src_data_rd_en[i]) begin
                    dhead[i] <= dhead[i] + 11'd1;
                    dpops[i] <= dpops[i] + 1;
                end
            end
        end
    end

    // MAC-side monitor.
    int          cyc = 0;
    int          wcnt = 0;
    int          lcnt = 0;
    logic [31:0] wlog [2048];
    int          wcyc [2048];
    logic [LB-1:0] llog [64];
    int          lcyc [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (daqo_data_wr_en) begin
            wlog[wcnt] <= daqo_data;
            wcyc[wcnt] <= cyc;
            wcnt       <= wcnt + 1;
        end
        if (daqo_len_wr_en) begin
            llog[lcnt] <= daqo_len;
            lcyc[lcnt] <= cyc;
            lcnt       <= lcnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input int s, input int len, input logic [31:0] base);
        for (int k = 0; k < len; k++) begin
            dmem[s][dtail[s]] = base + 32'(k);
            dtail[s] = dtail[s] + 11'd1;
        end
        lmem[s][ltail[s]] = LB'(len);
        ltail[s] = ltail[s] + 11'd1;
    endtask

    task automatic wait_wcnt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (wcnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_lcnt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (lcnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++; if ({src_len_rd_en, src_data_rd_en, daqo_data_wr_en, daqo_len_wr_en} !== 10'd0) begin
            errs++; $display("FAIL reset_strobes_held: got %b expected 0",
                             {src_len_rd_en, src_data_rd_en, daqo_data_wr_en, daqo_len_wr_en});
        end
        rst = 1'b0;
        tick();
        vecs++; if (grant_dbg !== 5'h00) begin
            errs++; $display("FAIL reset_grant_dbg: got %h expected 00", grant_dbg); end
        vecs++; if (drop_cnt !== 16'd0) begin
            errs++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        vecs++; if (src_len_rd_en !== 4'b0 || src_data_rd_en !== 4'b0) begin
            errs++; $display("FAIL reset_rd_en: got %b/%b expected 0/0", src_len_rd_en,
                             src_data_rd_en); end
        vecs++; if (daqo_data_wr_en !== 1'b0 || daqo_len_wr_en !== 1'b0) begin
            errs++; $display("FAIL reset_wr_en: got %b/%b expected 0/0", daqo_data_wr_en,
                             daqo_len_wr_en); end
        vecs++; if (daqo_data !== 32'd0 || daqo_len !== 9'd0) begin
            errs++; $display("FAIL reset_outputs: got %h/%h expected 0/0", daqo_data, daqo_len); end
        src_enable = 4'hF;
    endtask

    task automatic test_single();
        int wb = wcnt;
        int lb = lcnt;
        int t0 = cyc;
        int dp = dpops[0];
        bit ok;
        push_rec(0, 3, 32'h0000_000A);
        tick();
        vecs++; if (grant_dbg !== 5'h04 || src_len_rd_en !== 4'b0001) begin
            errs++; $display("FAIL single_len_state: got %h/%b expected 04/0001", grant_dbg,
                             src_len_rd_en); end
        wait_lcnt(lb + 1, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL single_wait: got timeout expected len write"); end
        vecs++; if (wcnt - wb !== 3) begin
            errs++; $display("FAIL single_count: got %0d expected 3", wcnt - wb); end
        vecs++; if (wlog[wb] !== 32'hA || wlog[wb+1] !== 32'hB || wlog[wb+2] !== 32'hC) begin
            errs++; $display("FAIL single_data: got %h %h %h expected a b c", wlog[wb], wlog[wb+1],
                             wlog[wb+2]); end
        vecs++; if (wcyc[wb] !== t0 + 2 || wcyc[wb+2] !== t0 + 4) begin
            errs++; $display("FAIL single_data_timing: got %0d..%0d expected %0d..%0d",
                             wcyc[wb], wcyc[wb+2], t0 + 2, t0 + 4); end
        vecs++; if (lcyc[lb] !== t0 + 5 || llog[lb] !== 9'd3) begin
            errs++; $display("FAIL single_len: got len %0d at %0d expected 3 at %0d", llog[lb],
                             lcyc[lb], t0 + 5); end
        vecs++; if (dpops[0] - dp !== 3 || grant_dbg !== 5'h00) begin
            errs++; $display("FAIL single_end: got pops %0d dbg %h expected 3 00", dpops[0] - dp,
                             grant_dbg); end
    endtask

    task automatic test_rr_order();
        int wb;
        int lb;
        bit ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb = wcnt;
        lb = lcnt;
        push_rec(0, 2, 32'h100);
        push_rec(1, 2, 32'h110);
        push_rec(3, 2, 32'h130);
        wait_lcnt(lb + 3, 60, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rr_wait: got timeout expected 3 records"); end
        vecs++; if (wlog[wb] !== 32'h100 || wlog[wb+1] !== 32'h101 || wlog[wb+2] !== 32'h110 ||
                    wlog[wb+3] !== 32'h111 || wlog[wb+4] !== 32'h130 || wlog[wb+5] !== 32'h131) begin
            errs++; $display("FAIL rr_order: got %h %h %h %h %h %h expected 100 101 110 111 130 131",
                             wlog[wb], wlog[wb+1], wlog[wb+2], wlog[wb+3], wlog[wb+4], wlog[wb+5]);
        end
        vecs++; if (wcyc[wb+2] - wcyc[wb] !== 5) begin
            errs++; $display("FAIL rr_back_to_back: got %0d cycles expected 5",
                             wcyc[wb+2] - wcyc[wb]); end
        vecs++; if (llog[lb] !== 9'd2 || llog[lb+2] !== 9'd2) begin
            errs++; $display("FAIL rr_len: got %0d %0d expected 2 2", llog[lb], llog[lb+2]); end
        push_rec(2, 2, 32'h120);
        push_rec(0, 2, 32'h140);
        wait_lcnt(lb + 5, 40, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rr_refill_wait: got timeout expected 2 records"); end
        vecs++; if (wlog[wb+6] !== 32'h140 || wlog[wb+8] !== 32'h120) begin
            errs++; $display("FAIL rr_refill: got %h %h expected 140 120", wlog[wb+6], wlog[wb+8]); end
    endtask

    task automatic test_drop();
        int wb = wcnt;
        int lb = lcnt;
        int t0 = cyc;
        int dp = dpops[2];
        int lp = lpops[2];
        bit ok;
        push_rec(2, 0, 32'h0);
        push_rec(2, 400, 32'hB000_0000);
        push_rec(2, 5, 32'hC000_0000);
        wait_lcnt(lb + 1, 600, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL drop_wait: got timeout expected len write"); end
        vecs++; if (drop_cnt !== 16'd2) begin
            errs++; $display("FAIL drop_cnt2: got %0d expected 2", drop_cnt); end
        vecs++; if (wcnt - wb !== 5 || wlog[wb] !== 32'hC000_0000 || wlog[wb+4] !== 32'hC000_0004) begin
            errs++; $display("FAIL drop_pass: got %0d words %h..%h expected 5 c0000000..c0000004",
                             wcnt - wb, wlog[wb], wlog[wb+4]); end
        vecs++; if (llog[lb] !== 9'd5) begin
            errs++; $display("FAIL drop_len: got %0d expected 5", llog[lb]); end
        vecs++; if (dpops[2] - dp !== 405 || lpops[2] - lp !== 3) begin
            errs++; $display("FAIL drop_pops: got %0d/%0d expected 405/3", dpops[2] - dp,
                             lpops[2] - lp); end
        vecs++; if (wcyc[wb] !== t0 + 406 || lcyc[lb] !== t0 + 411) begin
            errs++; $display("FAIL drop_timing: got %0d/%0d expected %0d/%0d", wcyc[wb], lcyc[lb],
                             t0 + 406, t0 + 411); end
        // Boundary: one over the limit is dropped, exactly the limit passes.
        wb = wcnt;
        push_rec(2, 376, 32'hD000_0000);
        push_rec(2, 375, 32'hE000_0000);
        wait_lcnt(lb + 2, 900, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL limit_wait: got timeout expected len write"); end
        vecs++; if (drop_cnt !== 16'd3) begin
            errs++; $display("FAIL limit_drop_cnt: got %0d expected 3", drop_cnt); end
        vecs++; if (wcnt - wb !== 375 || wlog[wb] !== 32'hE000_0000 ||
                    wlog[wb+374] !== 32'hE000_0176) begin
            errs++; $display("FAIL limit_pass: got %0d words %h..%h expected 375 e0000000..e0000176",
                             wcnt - wb, wlog[wb], wlog[wb+374]); end
        vecs++; if (llog[lb+1] !== 9'd375) begin
            errs++; $display("FAIL limit_len: got %0d expected 375", llog[lb+1]); end
    endtask

    task automatic test_backpressure();
        int wb = wcnt;
        int lb = lcnt;
        int dp = dpops[1];
        bit ok;
        daqo_len_full = 1'b1;
        push_rec(1, 6, 32'h600);
        wait_wcnt(wb + 2, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL bp_wait_start: got timeout expected 2 words"); end
        daqo_data_full = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            vecs++; if (src_data_rd_en !== 4'b0 || daqo_data_wr_en !== 1'b0) begin
                errs++; $display("FAIL bp_data_stall%0d: got %b/%b expected 0/0", i, src_data_rd_en,
                                 daqo_data_wr_en); end
            tick();
        end
        daqo_data_full = 1'b0;
        wait_wcnt(wb + 6, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL bp_wait_data: got timeout expected 6 words"); end
        vecs++; if (wcyc[wb+2] - wcyc[wb+1] !== 5) begin
            errs++; $display("FAIL bp_gap: got %0d expected 5", wcyc[wb+2] - wcyc[wb+1]); end
        for (int i = 0; i < 6; i++) begin
            vecs++; if (wlog[wb+i] !== 32'h600 + 32'(i)) begin
                errs++; $display("FAIL bp_word%0d: got %h expected %h", i, wlog[wb+i],
                                 32'h600 + 32'(i)); end
        end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (daqo_len_wr_en !== 1'b0 || daqo_len !== 9'd6) begin
                errs++; $display("FAIL bp_len_stall%0d: got %b/%0d expected 0/6", i, daqo_len_wr_en,
                                 daqo_len); end
            tick();
        end
        daqo_len_full = 1'b0;
        wait_lcnt(lb + 1, 5, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL bp_wait_len: got timeout expected len write"); end
        vecs++; if (llog[lb] !== 9'd6 || lcyc[lb] - wcyc[wb+5] !== 4) begin
            errs++; $display("FAIL bp_len: got %0d after %0d expected 6 after 4", llog[lb],
                             lcyc[lb] - wcyc[wb+5]); end
        vecs++; if (wcnt - wb !== 6 || dpops[1] - dp !== 6) begin
            errs++; $display("FAIL bp_no_dup: got %0d words %0d pops expected 6 6", wcnt - wb,
                             dpops[1] - dp); end
    endtask

    task automatic test_reset_mid();
        int wb = wcnt;
        int lb;
        bit ok;
        push_rec(0, 12, 32'h700);
        wait_wcnt(wb + 2, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rstmid_wait: got timeout expected 2 words"); end
        rst = 1'b1;
        #1;
        vecs++; if (src_data_rd_en !== 4'b0 || daqo_data_wr_en !== 1'b0) begin
            errs++; $display("FAIL rstmid_same_cycle: got %b/%b expected 0/0", src_data_rd_en,
                             daqo_data_wr_en); end
        tick();
        rst = 1'b0;
        #1;
        vecs++; if (grant_dbg !== 5'h00 || drop_cnt !== 16'd0) begin
            errs++; $display("FAIL rstmid_state: got %h/%0d expected 00/0", grant_dbg, drop_cnt); end
        vecs++; if ({src_len_rd_en, src_data_rd_en, daqo_data_wr_en, daqo_len_wr_en} !== 10'd0) begin
            errs++; $display("FAIL rstmid_strobes: got %b expected 0",
                             {src_len_rd_en, src_data_rd_en, daqo_data_wr_en, daqo_len_wr_en}); end
        wb = wcnt;
        lb = lcnt;
        push_rec(1, 2, 32'h810);
        push_rec(0, 2, 32'h800);
        wait_lcnt(lb + 2, 30, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rstmid_wait2: got timeout expected 2 records"); end
        vecs++; if (wlog[wb] !== 32'h800 || wlog[wb+2] !== 32'h810) begin
            errs++; $display("FAIL rstmid_first_grant: got %h %h expected 800 810", wlog[wb],
                             wlog[wb+2]); end
    endtask

    task automatic test_enable();
        int wb = wcnt;
        int lb = lcnt;
        int lp;
        bit ok;
        push_rec(1, 4, 32'h900);
        wait_wcnt(wb + 1, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL en_wait: got timeout expected copy"); end
        src_enable = 4'b1101;
        push_rec(1, 2, 32'h910);
        wait_lcnt(lb + 1, 20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL en_wait_len: got timeout expected len write"); end
        vecs++; if (wcnt - wb !== 4 || wlog[wb+3] !== 32'h903 || llog[lb] !== 9'd4) begin
            errs++; $display("FAIL en_complete: got %0d words %h len %0d expected 4 903 4",
                             wcnt - wb, wlog[wb+3], llog[lb]); end
        lp = lpops[1];
        for (int i = 0; i < 10; i++) tick();
        vecs++; if (lpops[1] !== lp || lcnt !== lb + 1) begin
            errs++; $display("FAIL en_masked: got pops %0d lens %0d expected %0d %0d", lpops[1],
                             lcnt, lp, lb + 1); end
        push_rec(2, 1, 32'h920);
        wait_lcnt(lb + 2, 20, ok);
        vecs++; if (!ok || wlog[wb+4] !== 32'h920) begin
            errs++; $display("FAIL en_other_source: got %h expected 920", wlog[wb+4]); end
        src_enable = 4'hF;
        wait_lcnt(lb + 3, 20, ok);
        vecs++; if (!ok || wlog[wb+5] !== 32'h910) begin
            errs++; $display("FAIL en_reenable: got %h expected 910", wlog[wb+5]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
